// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: character-stream front end for a 16x2 LCD.
// Accepts one byte per valid/ready handshake and maintains a 32-byte frame
// image with a cursor. Clear and scroll are multi-cycle walks over the frame,
// one byte per cycle, during which the block is not ready.
module lcd_text_buffer #(
    parameter logic [7:0] FILL_CHAR   = 8'h20,
    parameter bit         WRAP_SCROLL = 1'b1
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic [7:0]   iCHAR,
    input  logic         iVALID,
    output logic         oREADY,
    output logic [255:0] oFB,
    output logic         oROW,
    output logic [3:0]   oCOL,
    output logic         oUPDATE
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CLEAR        = 2'd1,
        SCROLL_COPY  = 2'd2,
        SCROLL_BLANK = 2'd3
    } state_t;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_DEL = 8'h7F;

    state_t     state_q, state_d;
    logic [4:0] k_q, k_d;
    logic       row_q, row_d;
    logic [3:0] col_q, col_d;
    logic       upd_q, upd_d;
    logic [7:0] fb_q [32];

    // Single frame write port, driven by the decode/FSM logic below.
    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;
    logic       printable;

    assign printable = (iCHAR >= 8'h20) && (iCHAR != CH_DEL);

    // Next-state, cursor and frame-write decode for all FSM states.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        upd_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = 5'd0;
        wr_data = FILL_CHAR;

        unique case (state_q)
            IDLE: begin
                if (iVALID) begin
                    if (printable) begin
                        wr_en   = 1'b1;
                        wr_idx  = {row_q, col_q};
                        wr_data = iCHAR;
                        if (col_q != 4'd15) begin
                            col_d = col_q + 4'd1;
                            upd_d = 1'b1;
                        end else if (!row_q) begin
                            row_d = 1'b1;
                            col_d = 4'd0;
                            upd_d = 1'b1;
                        end else if (WRAP_SCROLL) begin
                            // Update is reported once the scroll has completed.
                            col_d   = 4'd0;
                            state_d = SCROLL_COPY;
                            k_d     = 5'd0;
                        end else begin
                            upd_d = 1'b1;
                        end
                    end else if (iCHAR == CH_CR) begin
                        col_d = 4'd0;
                    end else if (iCHAR == CH_LF) begin
                        row_d = 1'b1;
                        col_d = 4'd0;
                        if (row_q && WRAP_SCROLL) begin
                            state_d = SCROLL_COPY;
                            k_d     = 5'd0;
                        end
                    end else if (iCHAR == CH_BS) begin
                        if (col_q != 4'd0) begin
                            col_d  = col_q - 4'd1;
                            wr_en  = 1'b1;
                            wr_idx = {row_q, col_q - 4'd1};
                            upd_d  = 1'b1;
                        end else if (row_q) begin
                            row_d  = 1'b0;
                            col_d  = 4'd15;
                            wr_en  = 1'b1;
                            wr_idx = 5'd15;
                            upd_d  = 1'b1;
                        end
                    end else if (iCHAR == CH_FF) begin
                        row_d   = 1'b0;
                        col_d   = 4'd0;
                        state_d = CLEAR;
                        k_d     = 5'd0;
                    end
                end
            end
            CLEAR: begin
                wr_en  = 1'b1;
                wr_idx = k_q;
                if (k_q == 5'd31) begin
                    state_d = IDLE;
                    upd_d   = 1'b1;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            SCROLL_COPY: begin
                wr_en   = 1'b1;
                wr_idx  = {1'b0, k_q[3:0]};
                wr_data = fb_q[{1'b1, k_q[3:0]}];
                if (k_q[3:0] == 4'd15) begin
                    state_d = SCROLL_BLANK;
                    k_d     = 5'd0;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            SCROLL_BLANK: begin
                wr_en  = 1'b1;
                wr_idx = {1'b1, k_q[3:0]};
                if (k_q[3:0] == 4'd15) begin
                    state_d = IDLE;
                    upd_d   = 1'b1;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: state, walk index, cursor and update pulse.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= IDLE;
            k_q     <= 5'd0;
            row_q   <= 1'b0;
            col_q   <= 4'd0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            upd_q   <= upd_d;
        end
    end

    // Frame image storage with one write per cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            // NOTE: the frame is flip-flops, not RAM, so it can be reset to blank immediately.
            for (int i = 0; i < 32; i++) fb_q[i] <= FILL_CHAR;
        end else if (wr_en) begin
            fb_q[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_fb
        assign oFB[g*8 +: 8] = fb_q[g];
    end

    assign oREADY  = (state_q == IDLE);
    assign oROW    = row_q;
    assign oCOL    = col_q;
    assign oUPDATE = upd_q;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Testbench for lcd_text_buffer: a table of single-byte vectors plus
// hand-written sequences for scroll, clear, mid-clear reset and no-wrap mode.
module tb_lcd_text_buffer;

    logic         iCLK = 1'b0;
    logic         iRST_N = 1'b0;
    logic [7:0]   ch_w = 8'h00, ch_n = 8'h00;
    logic         vld_w = 1'b0, vld_n = 1'b0;
    logic         rdy_w, rdy_n;
    logic [255:0] fb_w, fb_n;
    logic         row_w, row_n;
    logic [3:0]   col_w, col_n;
    logic         upd_w, upd_n;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] ALL_FILL = {32{8'h20}};

    always #5 iCLK = ~iCLK;

    lcd_text_buffer #(.FILL_CHAR(8'h20), .WRAP_SCROLL(1'b1)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCHAR(ch_w), .iVALID(vld_w),
        .oREADY(rdy_w), .oFB(fb_w), .oROW(row_w), .oCOL(col_w), .oUPDATE(upd_w)
    );

    lcd_text_buffer #(.FILL_CHAR(8'h20), .WRAP_SCROLL(1'b0)) dut_nw (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCHAR(ch_n), .iVALID(vld_n),
        .oREADY(rdy_n), .oFB(fb_n), .oROW(row_n), .oCOL(col_n), .oUPDATE(upd_n)
    );

    typedef struct {
        logic [7:0] ch;
        logic       row;
        logic [3:0] col;
        logic       upd;
        int         idx;
        logic [7:0] byt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fbb(input logic [255:0] fb, input int i);
        return fb[i*8 +: 8];
    endfunction

    // Drive one byte into the selected instance; returns 1 time unit after the accepting edge.
    task automatic send(input bit nw, input logic [7:0] b);
        @(negedge iCLK);
        if (nw) begin ch_n = b; vld_n = 1'b1; end
        else    begin ch_w = b; vld_w = 1'b1; end
        @(posedge iCLK);
        #1;
        vld_w = 1'b0;
        vld_n = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRST_N = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    // Count cycles until ready returns, bounded; also counts update pulses while busy.
    task automatic wait_ready(output int cycles, output int pulses);
        cycles = 0;
        pulses = 0;
        while (!rdy_w && cycles < 100) begin
            if (upd_w) pulses++;
            @(posedge iCLK);
            #1;
            cycles++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, pls;

        vecs[0]  = '{8'h41, 1'b0, 4'd1,  1'b1, 0,  8'h41};
        vecs[1]  = '{8'h42, 1'b0, 4'd2,  1'b1, 1,  8'h42};
        vecs[2]  = '{8'h0D, 1'b0, 4'd0,  1'b0, 1,  8'h42};
        vecs[3]  = '{8'h07, 1'b0, 4'd0,  1'b0, 0,  8'h41};
        vecs[4]  = '{8'h7F, 1'b0, 4'd0,  1'b0, 0,  8'h41};
        vecs[5]  = '{8'h78, 1'b0, 4'd1,  1'b1, 0,  8'h78};
        vecs[6]  = '{8'h0A, 1'b1, 4'd0,  1'b0, 16, 8'h20};
        vecs[7]  = '{8'hC3, 1'b1, 4'd1,  1'b1, 16, 8'hC3};
        vecs[8]  = '{8'h08, 1'b1, 4'd0,  1'b1, 16, 8'h20};
        vecs[9]  = '{8'h08, 1'b0, 4'd15, 1'b1, 15, 8'h20};
        vecs[10] = '{8'h0D, 1'b0, 4'd0,  1'b0, 1,  8'h42};
        vecs[11] = '{8'h08, 1'b0, 4'd0,  1'b0, 0,  8'h78};

        // Reset state
        do_reset();
        #1;
        check("reset fb", fb_w, ALL_FILL);
        check("reset row", 256'(row_w), 256'(0));
        check("reset col", 256'(col_w), 256'(0));
        check("reset ready", 256'(rdy_w), 256'(1));
        check("reset upd", 256'(upd_w), 256'(0));

        // Table-driven single-byte vectors
        for (int i = 0; i < 12; i++) begin
            check($sformatf("vec%0d ready", i), 256'(rdy_w), 256'(1));
            send(1'b0, vecs[i].ch);
            check($sformatf("vec%0d row", i), 256'(row_w), 256'(vecs[i].row));
            check($sformatf("vec%0d col", i), 256'(col_w), 256'(vecs[i].col));
            check($sformatf("vec%0d upd", i), 256'(upd_w), 256'(vecs[i].upd));
            check($sformatf("vec%0d byte", i), 256'(fbb(fb_w, vecs[i].idx)), 256'(vecs[i].byt));
        end

        // Fill both rows then scroll on the 32nd byte
        do_reset();
        for (int i = 0; i < 32; i++) begin
            send(1'b0, 8'(8'h30 + i));
            if (i == 16) begin
                check("fill17 byte16", 256'(fbb(fb_w, 16)), 256'(8'h40));
                check("fill17 cursor", 256'({row_w, col_w}), 256'({1'b1, 4'd1}));
            end
        end
        check("scroll busy", 256'(rdy_w), 256'(0));
        wait_ready(cyc, pls);
        check("scroll cycles", 256'(cyc), 256'(32));
        check("scroll early upd", 256'(pls), 256'(0));
        check("scroll upd", 256'(upd_w), 256'(1));
        check("scroll cursor", 256'({row_w, col_w}), 256'({1'b1, 4'd0}));
        for (int i = 0; i < 16; i++) begin
            check($sformatf("scroll row0 b%0d", i), 256'(fbb(fb_w, i)), 256'(8'(8'h40 + i)));
            check($sformatf("scroll row1 b%0d", i), 256'(fbb(fb_w, 16 + i)), 256'(8'h20));
        end
        send(1'b0, 8'h50);
        check("post scroll byte16", 256'(fbb(fb_w, 16)), 256'(8'h50));
        check("post scroll col", 256'(col_w), 256'(1));

        // Clear after writing row 0
        do_reset();
        for (int i = 0; i < 16; i++) send(1'b0, (i < 10) ? 8'(8'h30 + i) : 8'(8'h41 + i - 10));
        check("row0 byte15", 256'(fbb(fb_w, 15)), 256'(8'h46));
        send(1'b0, 8'h0C);
        check("clear cursor", 256'({row_w, col_w}), 256'(0));
        check("clear accept upd", 256'(upd_w), 256'(0));
        wait_ready(cyc, pls);
        check("clear cycles", 256'(cyc), 256'(32));
        check("clear early upd", 256'(pls), 256'(0));
        check("clear upd", 256'(upd_w), 256'(1));
        check("clear fb", fb_w, ALL_FILL);
        @(posedge iCLK);
        #1;
        check("clear single upd", 256'(upd_w), 256'(0));

        // Async reset in the middle of a clear
        do_reset();
        for (int i = 0; i < 16; i++) send(1'b0, 8'(8'h30 + i));
        send(1'b0, 8'h0C);
        repeat (7) @(posedge iCLK);
        #1;
        check("midclear byte6", 256'(fbb(fb_w, 6)), 256'(8'h20));
        check("midclear byte10", 256'(fbb(fb_w, 10)), 256'(8'h3A));
        #2;
        iRST_N = 1'b0;
        #1;
        check("midclear reset fb", fb_w, ALL_FILL);
        check("midclear reset ready", 256'(rdy_w), 256'(1));
        @(negedge iCLK);
        iRST_N = 1'b1;
        send(1'b0, 8'h5A);
        check("after reset write", 256'(fbb(fb_w, 0)), 256'(8'h5A));
        check("after reset col", 256'(col_w), 256'(1));

        // No-wrap instance: 40 printables, last one lands on byte 31
        for (int i = 0; i < 40; i++) begin
            if (!rdy_n) begin
                total++;
                bad++;
                $display("FAIL nowrap ready at byte %0d: got 0 expected 1", i);
            end else begin
                total++;
            end
            send(1'b1, 8'(8'h21 + i));
        end
        check("nowrap byte31", 256'(fbb(fb_n, 31)), 256'(8'h48));
        check("nowrap byte30", 256'(fbb(fb_n, 30)), 256'(8'h3F));
        check("nowrap byte0", 256'(fbb(fb_n, 0)), 256'(8'h21));
        check("nowrap cursor", 256'({row_n, col_n}), 256'({1'b1, 4'd15}));
        send(1'b1, 8'h0A);
        check("nowrap lf ready", 256'(rdy_n), 256'(1));
        check("nowrap lf cursor", 256'({row_n, col_n}), 256'({1'b1, 4'd0}));
        check("nowrap lf upd", 256'(upd_n), 256'(0));
        check("nowrap lf byte0", 256'(fbb(fb_n, 0)), 256'(8'h21));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
